// File: rtl/mips_div_unit_pkg.sv
// Shared definitions for the iterative MIPS divider: ALU op bit indices,
// divider FSM encoding, default datapath width and the two's complement helper.
package mips_div_unit_pkg;

    localparam int DIV_DATA_W = 32;

    localparam int OP_ADD   = 0;
    localparam int OP_ADDU  = 1;
    localparam int OP_SUB   = 2;
    localparam int OP_SUBU  = 3;
    localparam int OP_AND   = 4;
    localparam int OP_OR    = 5;
    localparam int OP_XOR   = 6;
    localparam int OP_NOR   = 7;
    localparam int OP_SLT   = 8;
    localparam int OP_SLTU  = 9;
    localparam int OP_SLL   = 10;
    localparam int OP_SRL   = 11;
    localparam int OP_MULT  = 12;
    localparam int OP_MULTU = 13;
    localparam int OP_DIV   = 14;
    localparam int OP_DIVU  = 15;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic [DIV_DATA_W-1:0] negate(input logic [DIV_DATA_W-1:0] x);
        return ~x + 1'b1;
    endfunction

endpackage

// File: rtl/mips_div_unit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when it fits.
module mips_div_unit_div_step
    import mips_div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W-1:0] rem_in,
    input  logic              dvd_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic              qbit
);

    // One extra bit: an unsigned divisor near 2^DATA_W can leave rem_shift above DATA_W bits.
    logic [DATA_W:0] rem_shift;
    logic [DATA_W:0] diff;

    always_comb begin
        rem_shift = {rem_in, dvd_bit};
        diff      = rem_shift - {1'b0, divisor};
        qbit      = (rem_shift >= {1'b0, divisor});
        rem_out   = qbit ? diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
    end

endmodule

// File: rtl/mips_div_unit.sv
// Multi-cycle DIV/DIVU unit: magnitudes are divided one quotient bit per cycle,
// then sign-corrected into the registered quotient (LO) and remainder (HI).
module mips_div_unit
    import mips_div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              div_valid,
    input  logic              div_signed,
    input  logic [DATA_W-1:0] div_src1,
    input  logic [DATA_W-1:0] div_src2,
    input  logic              div_cancel,
    output logic              div_ready,
    output logic              div_busy,
    output logic              div_done,
    output logic [DATA_W-1:0] div_quot,
    output logic [DATA_W-1:0] div_rem,
    output div_state_e        div_state
);

    // Handshake: a request is taken on any edge where div_valid=1, div_ready=1 and
    // div_cancel=0; div_done pulses once with the result and needs no acknowledge.

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dvd_q, dvd_d;
    logic [DATA_W-1:0] dsr_q, dsr_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] src1_q, src1_d;
    logic              sgn1_q, sgn1_d;
    logic              sgn2_q, sgn2_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              done_q, done_d;

    logic [DATA_W:0]   mag1, mag2;
    logic [DATA_W-1:0] step_rem, q_mag;
    logic              step_qbit;
    logic              accept;

    mips_div_unit_div_step #(.DATA_W(DATA_W)) u_step (
        .rem_in  (acc_q),
        .dvd_bit (dvd_q[DATA_W-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .qbit    (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        acc_d   = acc_q;
        src1_d  = src1_q;
        sgn1_d  = sgn1_q;
        sgn2_d  = sgn2_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        done_d  = 1'b0;

        // Magnitudes in DATA_W+1 bits so the most negative operand converts exactly.
        mag1 = {1'b0, div_src1};
        mag2 = {1'b0, div_src2};
        if (div_signed && div_src1[DATA_W-1]) mag1 = ~mag1 + (DATA_W+1)'(1);
        if (div_signed && div_src2[DATA_W-1]) mag2 = ~mag2 + (DATA_W+1)'(1);

        q_mag  = {dvd_q[DATA_W-2:0], step_qbit};
        accept = div_valid && !div_cancel && (state_q != DIV_RUN);

        case (state_q)
            DIV_IDLE, DIV_DONE: begin
                state_d = DIV_IDLE;
                if (accept) begin
                    state_d = DIV_RUN;
                    cnt_d   = '0;
                    dvd_d   = mag1[DATA_W-1:0];
                    dsr_d   = mag2[DATA_W-1:0];
                    acc_d   = '0;
                    src1_d  = div_src1;
                    sgn1_d  = div_signed & div_src1[DATA_W-1];
                    sgn2_d  = div_signed & div_src2[DATA_W-1];
                    zero_d  = (div_src2 == '0);
                end
            end
            DIV_RUN: begin
                // The dividend register doubles as the quotient shift register.
                dvd_d = q_mag;
                acc_d = step_rem;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DIV_DONE;
                    done_d  = 1'b1;
                    if (zero_q) begin
                        quot_d = '1;
                        rem_d  = src1_q;
                    end else begin
                        quot_d = (sgn1_q ^ sgn2_q) ? negate(q_mag) : q_mag;
                        rem_d  = sgn1_q ? negate(step_rem) : step_rem;
                    end
                end
            end
            default: state_d = DIV_IDLE;
        endcase

        if (div_cancel) begin
            state_d = DIV_IDLE;
            done_d  = 1'b0;
            quot_d  = quot_q;
            rem_d   = rem_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            acc_q   <= '0;
            src1_q  <= '0;
            sgn1_q  <= 1'b0;
            sgn2_q  <= 1'b0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            acc_q   <= acc_d;
            src1_q  <= src1_d;
            sgn1_q  <= sgn1_d;
            sgn2_q  <= sgn2_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign div_ready = (state_q != DIV_RUN);
    assign div_busy  = (state_q == DIV_RUN);
    assign div_done  = done_q;
    assign div_quot  = quot_q;
    assign div_rem   = rem_q;
    assign div_state = state_q;

endmodule
